// File: rtl/serializer_pkg.sv
// Shared types and constants for the byte-to-bit serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serializer_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    // Index presented first for a newly captured byte.
    function automatic logic [IDX_W-1:0] first_index(input logic msb_first);
        return msb_first ? IDX_W'(DATA_W - 1) : '0;
    endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Bit index counter: loadable up/down counter that saturates at its last index.
// Latency: load or step takes effect on the rising edge after load_en/step_en.
// Backpressure: holds its value whenever step_en is low; never wraps past the last index.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset (index -> 0)
//   load_en, load_val - load a new start index (wins over step_en)
//   step_en           - advance by one in the selected direction
//   count_down        - 1: step down towards 0, 0: step up towards DATA_W-1
//   idx               - current index
//   is_last           - current index is the final one for the direction
module bit_index_counter
    import serializer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_val,
    input  logic             step_en,
    input  logic             count_down,
    output logic [IDX_W-1:0] idx,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] LAST_UP = IDX_W'(DATA_W - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        is_last = count_down ? (idx_q == '0) : (idx_q == LAST_UP);
    end

    always_comb begin
        idx_d = idx_q;
        if (load_en) begin
            idx_d = load_val;
        end else if (step_en && !is_last) begin
            // Final transfer leaves the index parked rather than wrapping.
            idx_d = count_down ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/byte_bit_serializer.sv
// Byte-to-bit serializer: captures a byte on load and presents it one bit per transfer.
// Latency: first bit valid 1 cycle after the load edge; 8 SEND cycles min, 1 DONE cycle, then IDLE.
// Backpressure: valid/ready per bit; bit_index/bit_value hold while ready is low, no timeout.
//
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   load, data_in          - capture request and byte (honoured only in IDLE)
//   ready                  - downstream accepts the presented bit
//   valid_out              - bit_index/bit_value valid (registered, independent of ready)
//   bit_index, bit_value   - presented bit position and value (0 when not sending)
//   busy                   - byte in flight (SEND or DONE)
//   done                   - one-cycle pulse after the last bit transfers
module byte_bit_serializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load,
    input  logic [DATA_W-1:0]                data_in,
    input  logic                             ready,
    output logic                             valid_out,
    output logic [serializer_pkg::IDX_W-1:0] bit_index,
    output logic                             bit_value,
    output logic                             busy,
    output logic                             done
);

    localparam int  IDX_W      = serializer_pkg::IDX_W;
    localparam logic COUNT_DOWN = (MSB_FIRST != 0);

    serializer_pkg::ser_state_t state_q;
    serializer_pkg::ser_state_t state_d;

    logic [DATA_W-1:0] byte_q;
    logic [DATA_W-1:0] byte_d;

    logic             capture;
    logic             xfer;
    logic [IDX_W-1:0] idx;
    logic             idx_last;

    // A transfer needs a registered valid plus ready; capture only in IDLE,
    // so load during SEND/DONE is simply ignored.
    always_comb begin
        capture = (state_q == serializer_pkg::IDLE) && load;
        xfer    = (state_q == serializer_pkg::SEND) && ready;
    end

    bit_index_counter u_idx (
        .clk        (clk),
        .reset      (reset),
        .load_en    (capture),
        .load_val   (serializer_pkg::first_index(COUNT_DOWN)),
        .step_en    (xfer),
        .count_down (COUNT_DOWN),
        .idx        (idx),
        .is_last    (idx_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= serializer_pkg::IDLE;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        unique case (state_q)
            serializer_pkg::IDLE: begin
                if (capture) begin
                    byte_d  = data_in;
                    state_d = serializer_pkg::SEND;
                end
            end
            serializer_pkg::SEND: begin
                if (xfer && idx_last) begin
                    state_d = serializer_pkg::DONE;
                end
            end
            serializer_pkg::DONE: begin
                state_d = serializer_pkg::IDLE;
            end
            default: begin
                state_d = serializer_pkg::IDLE;
            end
        endcase
    end

    // Output logic: everything decodes from registered state; the held
    // byte is read by index rather than shifted.
    always_comb begin
        valid_out = 1'b0;
        bit_index = '0;
        bit_value = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            serializer_pkg::SEND: begin
                valid_out = 1'b1;
                bit_index = idx;
                bit_value = byte_q[idx];
                busy      = 1'b1;
            end
            serializer_pkg::DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_byte_bit_serializer.sv
// Directed bench for byte_bit_serializer: MSB-first and LSB-first instances.
// Inputs are driven and outputs sampled on the falling clock edge.
// Scenarios: reset, MSB/LSB sequences, stall, ignored load, abort, back-to-back.
module tb_byte_bit_serializer;

    logic clk;
    logic reset;

    logic       m_load, m_ready, m_valid, m_val, m_busy, m_done;
    logic [7:0] m_data;
    logic [2:0] m_idx;

    logic       l_load, l_ready, l_valid, l_val, l_busy, l_done;
    logic [7:0] l_data;
    logic [2:0] l_idx;

    int tests;
    int fails;

    byte_bit_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .load      (m_load),
        .data_in   (m_data),
        .ready     (m_ready),
        .valid_out (m_valid),
        .bit_index (m_idx),
        .bit_value (m_val),
        .busy      (m_busy),
        .done      (m_done)
    );

    byte_bit_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .load      (l_load),
        .data_in   (l_data),
        .ready     (l_ready),
        .valid_out (l_valid),
        .bit_index (l_idx),
        .bit_value (l_val),
        .busy      (l_busy),
        .done      (l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({m_valid, m_idx, m_val, m_busy, m_done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_msb: got v=%b i=%0d b=%b busy=%b done=%b, want all 0",
                     m_valid, m_idx, m_val, m_busy, m_done);
        end
        tests++;
        if ({l_valid, l_idx, l_val, l_busy, l_done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_lsb: got v=%b i=%0d b=%b busy=%b done=%b, want all 0",
                     l_valid, l_idx, l_val, l_busy, l_done);
        end
        reset = 1'b1;
    endtask

    // 8'hA5 MSB first: (7,1)(6,0)(5,1)(4,0)(3,0)(2,1)(1,0)(0,1)
    task automatic test_msb_a5();
        logic [2:0] exp_i [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic       exp_b [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        m_load = 1'b1; m_data = 8'hA5; m_ready = 1'b1;
        @(negedge clk);
        m_load = 1'b0; m_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (m_valid !== 1'b1 || m_idx !== exp_i[i] || m_val !== exp_b[i] || m_busy !== 1'b1 || m_done !== 1'b0) begin
                fails++;
                $display("FAIL msb_a5_bit%0d: got v=%b i=%0d b=%b busy=%b done=%b, want v=1 i=%0d b=%b busy=1 done=0",
                         i, m_valid, m_idx, m_val, m_busy, m_done, exp_i[i], exp_b[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL msb_a5_done: got done=%b v=%b busy=%b, want done=1 v=0 busy=1", m_done, m_valid, m_busy);
        end
        @(negedge clk);
        tests++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL msb_a5_idle: got done=%b busy=%b v=%b, want 0 0 0", m_done, m_busy, m_valid);
        end
    endtask

    // 8'h01 LSB first: (0,1) then (1..7,0)
    task automatic test_lsb_01();
        l_load = 1'b1; l_data = 8'h01; l_ready = 1'b1;
        @(negedge clk);
        l_load = 1'b0; l_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (l_valid !== 1'b1 || l_idx !== 3'(i) || l_val !== (i == 0)) begin
                fails++;
                $display("FAIL lsb_01_bit%0d: got v=%b i=%0d b=%b, want v=1 i=%0d b=%b",
                         i, l_valid, l_idx, l_val, i, (i == 0));
            end
            @(negedge clk);
        end
        tests++;
        if (l_done !== 1'b1 || l_valid !== 1'b0) begin
            fails++;
            $display("FAIL lsb_01_done: got done=%b v=%b, want done=1 v=0", l_done, l_valid);
        end
        @(negedge clk);
        tests++;
        if (l_done !== 1'b0 || l_busy !== 1'b0) begin
            fails++;
            $display("FAIL lsb_01_idle: got done=%b busy=%b, want 0 0", l_done, l_busy);
        end
    endtask

    // 8'h3C = 0011_1100, ready low for 5 cycles after valid rises
    task automatic test_stall();
        logic [2:0] exp_i [7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic       exp_b [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        m_load = 1'b1; m_data = 8'h3C; m_ready = 1'b0;
        @(negedge clk);
        m_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (m_valid !== 1'b1 || m_idx !== 3'd7 || m_val !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: got v=%b i=%0d b=%b, want v=1 i=7 b=0", k, m_valid, m_idx, m_val);
            end
            if (k == 4) m_ready = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (m_valid !== 1'b1 || m_idx !== exp_i[i] || m_val !== exp_b[i]) begin
                fails++;
                $display("FAIL stall_bit%0d: got v=%b i=%0d b=%b, want v=1 i=%0d b=%b",
                         i, m_valid, m_idx, m_val, exp_i[i], exp_b[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (m_done !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_done: got done=%b v=%b, want done=1 v=0", m_done, m_valid);
        end
        @(negedge clk);
    endtask

    // 8'hFF, with a load of 8'h00 pulsed mid-byte that must be ignored
    task automatic test_ignore_load();
        m_load = 1'b1; m_data = 8'hFF; m_ready = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (m_valid !== 1'b1 || m_idx !== 3'(7 - i) || m_val !== 1'b1) begin
                fails++;
                $display("FAIL ignore_bit%0d: got v=%b i=%0d b=%b, want v=1 i=%0d b=1",
                         i, m_valid, m_idx, m_val, 7 - i);
            end
            if (i == 1) begin m_load = 1'b1; m_data = 8'h00; end
            if (i == 2) m_load = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (m_done !== 1'b1) begin
            fails++;
            $display("FAIL ignore_done: got done=%b, want 1", m_done);
        end
        @(negedge clk);
        tests++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL ignore_idle: got busy=%b v=%b, want 0 0", m_busy, m_valid);
        end
    endtask

    // 8'h96 aborted by reset after 3 transfers, then 8'h5A = 0101_1010
    task automatic test_abort();
        logic exp_b [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        m_load = 1'b1; m_data = 8'h96; m_ready = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || m_idx !== 3'd4) begin
            fails++;
            $display("FAIL abort_pre: got v=%b i=%0d, want v=1 i=4", m_valid, m_idx);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({m_valid, m_idx, m_val, m_busy, m_done} !== 7'b0) begin
            fails++;
            $display("FAIL abort_async: got v=%b i=%0d b=%b busy=%b done=%b, want all 0",
                     m_valid, m_idx, m_val, m_busy, m_done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_nodone%0d: got done=%b busy=%b, want 0 0", k, m_done, m_busy);
            end
        end
        reset = 1'b1;
        m_load = 1'b1; m_data = 8'h5A;
        @(negedge clk);
        m_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (m_valid !== 1'b1 || m_idx !== 3'(7 - i) || m_val !== exp_b[i]) begin
                fails++;
                $display("FAIL abort_5a_bit%0d: got v=%b i=%0d b=%b, want v=1 i=%0d b=%b",
                         i, m_valid, m_idx, m_val, 7 - i, exp_b[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (m_done !== 1'b1) begin
            fails++;
            $display("FAIL abort_5a_done: got done=%b, want 1", m_done);
        end
        @(negedge clk);
    endtask

    // load held high with 8'hC3 = 1100_0011: 10-cycle period
    task automatic test_back_to_back();
        logic exp_b [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int ph;
        m_load = 1'b1; m_data = 8'hC3; m_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            ph = c % 10;
            tests++;
            if (ph < 8) begin
                if (m_valid !== 1'b1 || m_idx !== 3'(7 - ph) || m_val !== exp_b[ph] || m_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_c%0d: got v=%b i=%0d b=%b busy=%b, want v=1 i=%0d b=%b busy=1",
                             c, m_valid, m_idx, m_val, m_busy, 7 - ph, exp_b[ph]);
                end
            end else if (ph == 8) begin
                if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_c%0d_done: got done=%b v=%b busy=%b, want 1 0 1", c, m_done, m_valid, m_busy);
                end
            end else begin
                if (m_done !== 1'b0 || m_valid !== 1'b0 || m_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_c%0d_idle: got done=%b v=%b busy=%b, want 0 0 0", c, m_done, m_valid, m_busy);
                end
            end
            if (c == 19) m_load = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got busy=%b v=%b, want 0 0", m_busy, m_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        m_load = 1'b0; m_data = 8'h00; m_ready = 1'b0;
        l_load = 1'b0; l_data = 8'h00; l_ready = 1'b0;

        test_reset();
        test_msb_a5();
        test_lsb_01();
        test_stall();
        test_ignore_load();
        test_abort();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
